// File: rtl/fsm_arbiter4_if.sv
// -----------------------------------------------------------------------------
// fsm_arbiter4_if
// Request/grant bundle shared between four requesters and the fsm_arbiter4
// grant arbiter.
//   req_0..req_3 : requests, driven by the requester side (master)
//   gen_0..gen_3 : grants, driven by the arbiter side (slave)
// -----------------------------------------------------------------------------
interface fsm_arbiter4_if;
    logic req_0;
    logic req_1;
    logic req_2;
    logic req_3;
    logic gen_0;
    logic gen_1;
    logic gen_2;
    logic gen_3;

    // Requester side: raises requests, observes grants.
    modport master (
        output req_0, req_1, req_2, req_3,
        input  gen_0, gen_1, gen_2, gen_3
    );

    // Arbiter side: observes requests, drives grants.
    modport slave (
        input  req_0, req_1, req_2, req_3,
        output gen_0, gen_1, gen_2, gen_3
    );
endinterface

// File: rtl/fsm_arbiter4.sv
// -----------------------------------------------------------------------------
// fsm_arbiter4
// Four-requester grant arbiter built as a Moore FSM (IDLE, GNT0..GNT3).
// At most one grant is active; a granted requester keeps the grant until it
// drops its request, and every release passes through at least one IDLE cycle
// before the next grant is issued.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset (state -> IDLE, grants -> 0)
//   bus    : fsm_arbiter4_if.slave, req_0..req_3 in, gen_0..gen_3 out
//            (gen_n are registered and equal 1 exactly while in GNTn)
//
// Configuration macro:
//   FSM_ARBITER_ROUND_ROBIN_EN : when defined, IDLE arbitration rotates,
//   starting at (last granted index + 1) mod 4. When undefined, fixed
//   priority req_0 > req_1 > req_2 > req_3.
// -----------------------------------------------------------------------------
module fsm_arbiter4 (
    input  logic              clk,
    input  logic              reset,
    fsm_arbiter4_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GNT0 = 3'd1,
        ST_GNT1 = 3'd2,
        ST_GNT2 = 3'd3,
        ST_GNT3 = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  gen_q;
    logic [3:0]  gen_d;
    logic [3:0]  req_s;
    logic        any_req_s;
    logic [1:0]  win_idx_s;

`ifdef FSM_ARBITER_ROUND_ROBIN_EN
    logic [1:0]  last_q;
`endif

    assign req_s     = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
    assign any_req_s = |req_s;

    assign bus.gen_0 = gen_q[0];
    assign bus.gen_1 = gen_q[1];
    assign bus.gen_2 = gen_q[2];
    assign bus.gen_3 = gen_q[3];

    // Fixed priority: lowest asserted index wins.
    function automatic logic [1:0] fixed_pick(input logic [3:0] req);
        logic [1:0] idx;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Rotating priority starting at last+1. Scanning from the farthest
    // candidate down to the nearest lets the nearest asserted one win.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = last + 2'd1 + k[1:0];
            if (req[cand]) begin
                idx = cand;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Winner among current requests (only meaningful when any_req_s).
`ifdef FSM_ARBITER_ROUND_ROBIN_EN
    assign win_idx_s = rr_pick(req_s, last_q);
`else
    assign win_idx_s = fixed_pick(req_s);
`endif

    // Next-state and next-grant logic.
    always_comb begin
        state_d = ST_IDLE;
        gen_d   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    case (win_idx_s)
                        2'd0:    state_d = ST_GNT0;
                        2'd1:    state_d = ST_GNT1;
                        2'd2:    state_d = ST_GNT2;
                        2'd3:    state_d = ST_GNT3;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // A holder keeps the grant while its own request stays high;
            // other requests are ignored (no preemption).
            ST_GNT0: state_d = req_s[0] ? ST_GNT0 : ST_IDLE;
            ST_GNT1: state_d = req_s[1] ? ST_GNT1 : ST_IDLE;
            ST_GNT2: state_d = req_s[2] ? ST_GNT2 : ST_IDLE;
            ST_GNT3: state_d = req_s[3] ? ST_GNT3 : ST_IDLE;
            // Unused encodings recover to IDLE.
            default: state_d = ST_IDLE;
        endcase

        // Grants are decoded from the next state so the registered outputs
        // track the state register cycle for cycle.
        case (state_d)
            ST_GNT0: gen_d = 4'b0001;
            ST_GNT1: gen_d = 4'b0010;
            ST_GNT2: gen_d = 4'b0100;
            ST_GNT3: gen_d = 4'b1000;
            default: gen_d = 4'b0000;
        endcase
    end

    // State, registered grants and (optionally) last-grant tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gen_q   <= 4'b0000;
`ifdef FSM_ARBITER_ROUND_ROBIN_EN
            last_q  <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
`ifdef FSM_ARBITER_ROUND_ROBIN_EN
            // Record the winner on entry into a grant state.
            if ((state_q == ST_IDLE) && any_req_s) begin
                last_q <= win_idx_s;
            end else begin
                last_q <= last_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fsm_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_fsm_arbiter4
// Self-checking bench for fsm_arbiter4: a table of directed cycles, a few
// hand-written multi-cycle sequences, and random requests compared against a
// behavioural model that tracks "who holds the grant" as an integer.
// -----------------------------------------------------------------------------
module tb_fsm_arbiter4;

    logic clk;
    logic reset;

    fsm_arbiter4_if bus ();

    fsm_arbiter4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int checks;
    int errors;

    // Behavioural model state: current holder (-1 = nobody) and last winner.
    int holder;
    int last_win;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_gen;
    } vec_t;

    function automatic logic [3:0] dut_gen();
        return {bus.gen_3, bus.gen_2, bus.gen_1, bus.gen_0};
    endfunction

    function automatic logic [3:0] model_gen();
        logic [3:0] g;
        g = 4'b0000;
        if (holder >= 0) g[holder] = 1'b1;
        return g;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gen=%b expected %b at time %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, advance model on the rising edge,
    // then settle before the caller samples.
    task automatic step(input logic rst, input logic [3:0] req);
        int w;
        @(negedge clk);
        reset     = rst;
        bus.req_0 = req[0];
        bus.req_1 = req[1];
        bus.req_2 = req[2];
        bus.req_3 = req[3];
        @(posedge clk);
        if (rst) begin
            holder   = -1;
            last_win = 3;
        end else if (holder >= 0) begin
            if (!req[holder]) holder = -1;
        end else if (req != 4'b0000) begin
            w = -1;
`ifdef FSM_ARBITER_ROUND_ROBIN_EN
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req[(last_win + 1 + k) % 4]) w = (last_win + 1 + k) % 4;
            end
`else
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req[k]) w = k;
            end
`endif
            holder   = w;
            last_win = w;
        end
        #10;
    endtask

    initial begin
        vec_t vecs[$];
        logic [3:0] r;
        logic       rr;
        checks    = 0;
        errors    = 0;
        holder    = -1;
        last_win  = 3;
        reset     = 1'b1;
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        bus.req_2 = 1'b0;
        bus.req_3 = 1'b0;

`ifndef FSM_ARBITER_ROUND_ROBIN_EN
        // Reset, then idle cycles.
        vecs.push_back('{1'b1, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        // Single-cycle pulses on each requester.
        vecs.push_back('{1'b0, 4'b0001, 4'b0001});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 4'b0010, 4'b0010});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        vecs.push_back('{1'b0, 4'b1000, 4'b1000});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        // Priority among 1,2,3 with an IDLE cycle between grants.
        vecs.push_back('{1'b0, 4'b1110, 4'b0010});
        vecs.push_back('{1'b0, 4'b1110, 4'b0010});
        vecs.push_back('{1'b0, 4'b1100, 4'b0000});
        vecs.push_back('{1'b0, 4'b1100, 4'b0100});
        vecs.push_back('{1'b0, 4'b1000, 4'b0000});
        vecs.push_back('{1'b0, 4'b1000, 4'b1000});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        // No preemption of GNT3 by req_0.
        vecs.push_back('{1'b0, 4'b1000, 4'b1000});
        vecs.push_back('{1'b0, 4'b1001, 4'b1000});
        vecs.push_back('{1'b0, 4'b1001, 4'b1000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0001});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});
        // Reset mid-grant, request held through it.
        vecs.push_back('{1'b0, 4'b0100, 4'b0100});
        vecs.push_back('{1'b1, 4'b0100, 4'b0000});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d", i), dut_gen(), vecs[i].exp_gen);
        end
`else
        // Rotation: all four requesting, each holder drops for one cycle.
        step(1'b1, 4'b0000);
        check("rr_reset", dut_gen(), 4'b0000);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] one;
            one = 4'b0001 << (i % 4);
            step(1'b0, 4'b1111);
            check($sformatf("rr_grant%0d", i), dut_gen(), one);
            step(1'b0, 4'b1111 & ~one);
            check($sformatf("rr_idle%0d", i), dut_gen(), 4'b0000);
        end
`endif

        // Random requests against the model; rare resets.
        step(1'b1, 4'b0000);
        check("rnd_reset", dut_gen(), 4'b0000);
        for (int i = 0; i < 600; i++) begin
            r  = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 39) == 0);
            // Bias toward holding the current grant so long grants occur.
            if (holder >= 0 && $urandom_range(0, 3) != 0) r[holder] = 1'b1;
            step(rr, r);
            check($sformatf("rnd%0d", i), dut_gen(), model_gen());
            checks++;
            if ($countones(dut_gen()) > 1) begin
                errors++;
                $display("FAIL onehot%0d: got gen=%b expected at most one bit set", i, dut_gen());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_arbiter4.md
Name: fsm_arbiter4

Overview:
- Four-requester grant arbiter built as a 5-state Moore FSM: IDLE plus GNT0..GNT3.
- Sits between four request sources and a shared resource.
- Grants at most one requester at a time.
- A granted requester keeps the grant until it drops its request.

Parameters:
- None. State encoding is internal; a binary 3-bit encoding is used.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- req_0  input  1  request from requester 0 (highest fixed priority)
- req_1  input  1  request from requester 1
- req_2  input  1  request from requester 2
- req_3  input  1  request from requester 3 (lowest fixed priority)
- gen_0  output  1  grant to requester 0
- gen_1  output  1  grant to requester 1
- gen_2  output  1  grant to requester 2
- gen_3  output  1  grant to requester 3

Behaviour:
- Reset:
  - One clock domain (clk); reset is synchronous and active-high.
  - On a rising edge with reset=1, the state goes to IDLE and gen_0..gen_3 go to 0.
  - Reset overrides every transition, including mid-grant.
- States and transitions (evaluated on each rising edge with reset=0):
  - IDLE: req_0 -> GNT0; else req_1 -> GNT1; else req_2 -> GNT2; else req_3 -> GNT3; else stay in IDLE.
  - GNTn: if req_n=1, stay in GNTn; if req_n=0, go to IDLE. Other requests are ignored while in GNTn (no preemption).
  - After a grant releases, the FSM always spends at least one cycle in IDLE before issuing a new grant.
  - Unused encodings go to IDLE on the next edge.
- Outputs:
  - Moore outputs, registered: gen_n=1 exactly when state==GNTn.
  - Grants are one-hot or all-zero; never two grants at once.
- Latency:
  - A request sampled high in IDLE at edge k gives gen_n=1 after edge k.
  - req_n sampled low at edge m clears gen_n after edge m.
- Simultaneous requests in IDLE: the lowest index wins; the losers keep waiting and are re-arbitrated from IDLE.
- X/undriven requests are not handled specially; benches drive all req_* to 0 before releasing reset.

Optional Feature:
- Macro: FSM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 2-bit last-grant register (reset to 3) is added.
  - IDLE arbitration priority rotates, starting at (last+1) mod 4.
  - last is updated on entry to GNTn.
  - Under continuous contention, each requester is granted within 4 grant rounds.
- Undefined: fixed priority req_0 > req_1 > req_2 > req_3 as specified above; no extra registers.
- Port list is identical in both builds.

Test Plan:
- Reset: hold reset=1 for 1 cycle with all req=0 -> gen_0..3=0 and state IDLE; gen stays 0 for the following idle cycles.
- Single requester sequence (clock period 100 units): pulse req_0 for one cycle, idle one cycle, then req_1, req_2, req_3 in the same pattern -> each gen_n=1 for exactly one cycle after its req edge, returns to 0; never two gens high.
- Priority: from IDLE raise req_1, req_2 and req_3 together -> gen_1=1. Drop req_1 -> IDLE for 1 cycle, then gen_2=1. Drop req_2 -> IDLE, then gen_3=1.
- No preemption: hold req_3 to gain GNT3, then raise req_0 -> gen_3 stays 1 until req_3=0; after one IDLE cycle, gen_0=1.
- Reset mid-grant: while gen_2=1 and req_2=1, assert reset for one edge -> all gens 0 on that edge. After release with req_2 still 1 -> IDLE one cycle, then gen_2=1.
- FSM_ARBITER_ROUND_ROBIN_EN: hold all four reqs, dropping each granted req for one cycle -> grant order 0,1,2,3,0.
